pipeline_ctrl_unit: RTL and testbench

- Central stall/flush/debug sequencer for the 5-stage pipelined RV32I core.
- Detects load-use hazards between ID and EX, and flushes IF/ID, ID/EX and EX/MEM on a branch taken in MEM.
- Implements a debug halt/single-step/resume FSM that drains the pipeline before reporting halted.
- Drives PC hold, IF/ID hold/flush, ID/EX control-bubble mux select and EX/MEM flush. Keeps saturating performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_ctrl_unit_sat_counter.sv | 28 ++
 rtl/pipeline_ctrl_unit.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/debug sequencer.
// Holds the sequencer state encoding and the canonical NOP used for IF/ID flushes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_DRAIN      = 2'd1,
    S_HALTED     = 2'd2,
    S_STEP_ISSUE = 2'd3
  } ctrl_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the performance counters.
// Once it reaches all-ones it holds that value until it is cleared.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Stall/flush/debug sequencer for the 5-stage RV32I pipeline.
// Hazard controls are combinational; state, drain counter, halted and counters are registered.
module pipeline_ctrl_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLEAR,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             dbg_halt_req,
  input  logic             dbg_step_req,
  input  logic             dbg_resume,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int             DW         = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(PIPE_DEPTH);

  ctrl_state_t   r_state, w_next_state;
  logic [DW-1:0] r_drain_cnt, w_next_cnt;
  logic          r_halted;
  logic          w_load_use, w_branch, w_stall;

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign w_branch   = mem_branch_taken;
  // A taken branch squashes the dependent instruction, so its load-use is moot.
  assign w_stall    = w_load_use && !w_branch && !CLEAR;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_drain_cnt;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;

    case (r_state)
      S_RUN: begin
        if (dbg_halt_req) begin
          w_next_state = S_DRAIN;
          w_next_cnt   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        // A held ID instruction has not drained yet, so the count pauses.
        if (!w_stall) begin
          w_next_cnt = r_drain_cnt - 1'b1;
          if (r_drain_cnt <= DW'(1)) w_next_state = S_HALTED;
        end
      end
      S_HALTED: begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        if (dbg_resume)        w_next_state = S_RUN;
        else if (dbg_step_req) w_next_state = S_STEP_ISSUE;
      end
      S_STEP_ISSUE: begin
        w_next_state = S_DRAIN;
        w_next_cnt   = DRAIN_LOAD;
      end
      default: w_next_state = S_RUN;
    endcase

    if (w_branch) begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (w_load_use) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
    end

    if (CLEAR) begin
      w_next_state = S_RUN;
      w_next_cnt   = '0;
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_cnt;
      r_halted    <= (w_next_state == S_HALTED);
    end
  end

  assign halted = r_halted;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (CLEAR),
    .inc     (w_stall),
    .count   (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (CLEAR),
    .inc     (w_branch && !CLEAR),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: a behavioural model pushes the expected
// outputs for each driven cycle into a queue, which is popped and compared mid-cycle.
module tb_pipeline_ctrl_unit;

  localparam int PIPE_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET_N, CLEAR;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs2, ex_mem_read, mem_branch_taken;
  logic             dbg_halt_req, dbg_step_req, dbg_resume;
  logic             pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  always #5 CLK = ~CLK;

  pipeline_ctrl_unit #(.PIPE_DEPTH(PIPE_DEPTH), .CNT_W(CNT_W)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .CLEAR            (CLEAR),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs2      (id_uses_rs2),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .mem_branch_taken (mem_branch_taken),
    .dbg_halt_req     (dbg_halt_req),
    .dbg_step_req     (dbg_step_req),
    .dbg_resume       (dbg_resume),
    .pc_hold          (pc_hold),
    .if_id_hold       (if_id_hold),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_flush     (ex_mem_flush),
    .halted           (halted),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  typedef struct {
    logic             pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush, halted;
    logic [CNT_W-1:0] stall_count, flush_count;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: 0 RUN, 1 DRAIN, 2 HALTED, 3 STEP_ISSUE
  int m_state, m_cnt, m_stall, m_flush;
  bit m_halted;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_stall = 0; m_flush = 0; m_halted = 0;
  endtask

  task automatic cyc(input bit clr, input bit br, input bit mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input bit u2,
                     input bit h, input bit s, input bit r);
    exp_t e, got;
    bit   lu;
    int   nxt;
    CLEAR = clr; mem_branch_taken = br; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    dbg_halt_req = h; dbg_step_req = s; dbg_resume = r;

    lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    e.pc_hold = 0; e.if_id_hold = 0; e.if_id_flush = 0; e.id_ex_bubble = 0; e.ex_mem_flush = 0;
    e.halted = m_halted;
    e.stall_count = CNT_W'(m_stall);
    e.flush_count = CNT_W'(m_flush);
    if (!clr) begin
      if (br) begin
        e.if_id_flush = 1; e.id_ex_bubble = 1; e.ex_mem_flush = 1;
      end else if (lu) begin
        e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_bubble = 1;
      end else if (m_state == 1 || m_state == 2) begin
        e.pc_hold = 1; e.if_id_flush = 1;
      end
    end
    sb_q.push_back(e);

    @(negedge CLK);
    got = sb_q.pop_front();
    check("pc_hold",      {31'd0, pc_hold},      {31'd0, got.pc_hold});
    check("if_id_hold",   {31'd0, if_id_hold},   {31'd0, got.if_id_hold});
    check("if_id_flush",  {31'd0, if_id_flush},  {31'd0, got.if_id_flush});
    check("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, got.id_ex_bubble});
    check("ex_mem_flush", {31'd0, ex_mem_flush}, {31'd0, got.ex_mem_flush});
    check("halted",       {31'd0, halted},       {31'd0, got.halted});
    check("stall_count",  32'(stall_count),      32'(got.stall_count));
    check("flush_count",  32'(flush_count),      32'(got.flush_count));

    if (clr) begin
      model_reset();
    end else begin
      if (br) begin
        if (m_flush < CMAX) m_flush++;
      end else if (lu && m_stall < CMAX) begin
        m_stall++;
      end
      nxt = m_state;
      case (m_state)
        0: if (h) begin nxt = 1; m_cnt = PIPE_DEPTH; end
        1: if (!(lu && !br)) begin
             if (m_cnt == 1) nxt = 2;
             m_cnt--;
           end
        2: if (r) nxt = 0; else if (s) nxt = 3;
        3: begin nxt = 1; m_cnt = PIPE_DEPTH; end
        default: nxt = 0;
      endcase
      m_state  = nxt;
      m_halted = (nxt == 2);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc_hold"},      {31'd0, pc_hold},      32'd0);
    check({tag, "_if_id_hold"},   {31'd0, if_id_hold},   32'd0);
    check({tag, "_if_id_flush"},  {31'd0, if_id_flush},  32'd0);
    check({tag, "_id_ex_bubble"}, {31'd0, id_ex_bubble}, 32'd0);
    check({tag, "_ex_mem_flush"}, {31'd0, ex_mem_flush}, 32'd0);
    check({tag, "_halted"},       {31'd0, halted},       32'd0);
    check({tag, "_stall_count"},  32'(stall_count),      32'd0);
    check({tag, "_flush_count"},  32'(flush_count),      32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; mem_branch_taken = 0; dbg_halt_req = 0; dbg_step_req = 0; dbg_resume = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;

    idle(1);
    // Load-use on rs1, on rs2, rs2 match without rs2 use, and rd = x0
    cyc(0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0);
    cyc(0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0);
    cyc(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    idle(1);
    // Branch together with a load-use match: branch wins
    cyc(0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    idle(1);

    // Halt drain, then resume
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(6);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Halt drain with a load-use in DRAIN cycle 2, and a branch during DRAIN
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    cyc(0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Single step from HALTED, then step+resume together
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(6);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // Asynchronous reset in the middle of a drain
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    #2;
    RESET_N = 1'b0;
    #1;
    check_all_zero("rst_mid_drain");
    model_reset();
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    idle(2);

    // CLEAR during a drain with non-zero counters
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0);
    cyc(1, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 1, 1);
    idle(2);

    // Stall counter saturation
    for (int i = 0; i < 65540; i++) cyc(0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    check("stall_sat", 32'(stall_count), 32'h0000_FFFF);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
